rat_input_port: RTL and testbench

//  Input-side port-bus peripheral for the RAT MCU. Synchronises switches, debounces

---
 rtl/rat_input_port.sv | 132 +++++++++++++
 tb/tb_rat_input_port.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_input_port.sv
// Input-side port-bus peripheral for the RAT MCU: synchronises switches,
// debounces buttons, latches press events and raises a maskable interrupt.
module rat_input_port #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter logic [7:0]  SW_ID        = 8'h20,
  parameter logic [7:0]  BTN_ID       = 8'h24,
  parameter logic [7:0]  EVT_ID       = 8'h25,
  parameter logic [7:0]  MASK_ID      = 8'h26,
  parameter logic [7:0]  EVT_CLR_ID   = 8'h45
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [7:0]       SWITCHES,
  input  logic [N_BTN-1:0] BUTTONS,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       IN_PORT,
  output logic             INTR
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  // Two-flop synchronisers
  logic [7:0]       sw_meta_q,  sw_meta_d;
  logic [7:0]       sw_sync_q,  sw_sync_d;
  logic [N_BTN-1:0] btn_meta_q, btn_meta_d;
  logic [N_BTN-1:0] btn_sync_q, btn_sync_d;

  // Debounce state
  logic [N_BTN-1:0]            deb_q,      deb_d;
  logic [N_BTN-1:0]            deb_prev_q, deb_prev_d;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q,      cnt_d;

  // Event / mask / interrupt state
  logic [N_BTN-1:0] evt_q,  evt_d;
  logic [N_BTN-1:0] mask_q, mask_d;
  logic             intr_q, intr_d;

  // Bus decode helpers
  logic             wr_clr;
  logic             wr_mask;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] rise;

  // Only the low N_BTN bits of write data are meaningful
  logic unused_out_port;
  assign unused_out_port = &{1'b0, OUT_PORT};

  // Synchroniser next state: each stage follows the one before it
  always_comb begin
    sw_meta_d  = SWITCHES;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = BUTTONS;
    btn_sync_d = btn_meta_q;
  end

  // Per-button debounce: accept a change only after DEBOUNCE_CYC mismatching cycles
  always_comb begin
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (btn_sync_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = btn_sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Write decode, sticky press events, mask register and interrupt request
  always_comb begin
    wr_clr  = IO_STRB && (PORT_ID == EVT_CLR_ID);
    wr_mask = IO_STRB && (PORT_ID == MASK_ID);
    clr     = wr_clr ? OUT_PORT[N_BTN-1:0] : '0;
    rise    = deb_q & ~deb_prev_q;
    // A new rise overrides a simultaneous clear so no press is lost
    evt_d   = (evt_q & ~clr) | rise;
    mask_d  = wr_mask ? OUT_PORT[N_BTN-1:0] : mask_q;
    intr_d  = |(evt_q & mask_q);
  end

  // State registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      evt_q      <= '0;
      mask_q     <= '0;
      intr_q     <= 1'b0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      mask_q     <= mask_d;
      intr_q     <= intr_d;
    end
  end

  // Combinational read mux; reads never alter state
  always_comb begin
    IN_PORT = 8'h00;
    if (PORT_ID == SW_ID) begin
      IN_PORT = sw_sync_q;
    end else if (PORT_ID == BTN_ID) begin
      IN_PORT = 8'(deb_q);
    end else if (PORT_ID == EVT_ID) begin
      IN_PORT = 8'(evt_q);
    end else if (PORT_ID == MASK_ID) begin
      IN_PORT = 8'(mask_q);
    end
  end

  assign INTR = intr_q;

endmodule

// File: tb/tb_rat_input_port.sv
// Bench for rat_input_port: directed scenarios followed by random traffic,
// all checked against a window-based behavioural model.
module tb_rat_input_port;

  localparam int unsigned NB  = 4;
  localparam int unsigned DC  = 4;
  localparam logic [7:0]  ID_SW   = 8'h20;
  localparam logic [7:0]  ID_BTN  = 8'h24;
  localparam logic [7:0]  ID_EVT  = 8'h25;
  localparam logic [7:0]  ID_MASK = 8'h26;
  localparam logic [7:0]  ID_CLR  = 8'h45;

  logic          CLK;
  logic          RESET_N;
  logic [7:0]    SWITCHES;
  logic [NB-1:0] BUTTONS;
  logic [7:0]    PORT_ID;
  logic [7:0]    OUT_PORT;
  logic          IO_STRB;
  logic [7:0]    IN_PORT;
  logic          INTR;

  int n_vec = 0;
  int n_err = 0;

  rat_input_port #(.N_BTN(NB), .DEBOUNCE_CYC(DC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SWITCHES(SWITCHES), .BUTTONS(BUTTONS),
    .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
    .IN_PORT(IN_PORT), .INTR(INTR)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  logic [7:0]    raw_sw_hist[$];
  logic [NB-1:0] raw_btn_hist[$];
  logic [NB-1:0] bs_hist[$];
  logic [7:0]    m_sw;
  logic [NB-1:0] m_deb, m_deb_prev, m_evt, m_mask;
  logic          m_intr;

  task automatic model_reset();
    raw_sw_hist.delete();
    raw_btn_hist.delete();
    bs_hist.delete();
    m_sw = '0; m_deb = '0; m_deb_prev = '0;
    m_evt = '0; m_mask = '0; m_intr = 1'b0;
  endtask

  // One rising edge: inputs currently driven are the ones the DUT samples
  task automatic model_edge();
    logic [NB-1:0] bs_now, rise, clrv;
    logic          new_intr;
    bit            all_diff;
    // synchronised button level seen at this edge = raw value two edges back
    bs_now   = (raw_btn_hist.size() >= 2) ? raw_btn_hist[raw_btn_hist.size()-2] : '0;
    rise     = m_deb & ~m_deb_prev;
    clrv     = (IO_STRB && PORT_ID == ID_CLR) ? OUT_PORT[NB-1:0] : '0;
    new_intr = |(m_evt & m_mask);
    m_evt    = (m_evt & ~clrv) | rise;
    if (IO_STRB && PORT_ID == ID_MASK) m_mask = OUT_PORT[NB-1:0];
    m_intr   = new_intr;
    bs_hist.push_back(bs_now);
    m_deb_prev = m_deb;
    // a level is accepted once the last DC synchronised samples all disagree with it
    if (bs_hist.size() >= DC) begin
      for (int i = 0; i < NB; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++)
          if (bs_hist[bs_hist.size()-1-k][i] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) m_deb[i] = ~m_deb[i];
      end
    end
    raw_sw_hist.push_back(SWITCHES);
    raw_btn_hist.push_back(BUTTONS);
    m_sw = (raw_sw_hist.size() >= 2) ? raw_sw_hist[raw_sw_hist.size()-2] : '0;
    while (raw_sw_hist.size() > 8)  void'(raw_sw_hist.pop_front());
    while (raw_btn_hist.size() > 8) void'(raw_btn_hist.pop_front());
    while (bs_hist.size() > 8)      void'(bs_hist.pop_front());
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] id);
    case (id)
      ID_SW:   return m_sw;
      ID_BTN:  return {4'h0, m_deb};
      ID_EVT:  return {4'h0, m_evt};
      ID_MASK: return {4'h0, m_mask};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] other_id();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255));
    while (v == ID_SW || v == ID_BTN || v == ID_EVT || v == ID_MASK);
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] v);
    PORT_ID = id;
    #1;
    v = IN_PORT;
  endtask

  task automatic check_state();
    logic [7:0] ids[5];
    logic [7:0] v;
    ids = '{ID_SW, ID_BTN, ID_EVT, ID_MASK, other_id()};
    check("intr", 8'(INTR), 8'(m_intr));
    for (int j = 0; j < 5; j++) begin
      rd(ids[j], v);
      check($sformatf("rd_%h", ids[j]), v, m_read(ids[j]));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RESET_N) model_edge();
    #1;
    IO_STRB = 1'b0;
    check_state();
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
  endtask

  task automatic expect_rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
    logic [7:0] v;
    rd(id, v);
    check(tag, v, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    SWITCHES = 8'h00; BUTTONS = 4'hF; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    IO_STRB = 1'b0; RESET_N = 1'b0;
    model_reset();
    #5;

    // 1: reset with buttons held, then auto-detect after release
    ticks(2);
    expect_rd("rst_sw",   ID_SW,   8'h00);
    expect_rd("rst_btn",  ID_BTN,  8'h00);
    expect_rd("rst_evt",  ID_EVT,  8'h00);
    expect_rd("rst_mask", ID_MASK, 8'h00);
    check("rst_intr", 8'(INTR), 8'h00);
    RESET_N = 1'b1;
    ticks(5);
    expect_rd("held_btn_c5", ID_BTN, 8'h00);
    tick();
    expect_rd("held_btn_c6", ID_BTN, 8'h0F);
    tick();
    expect_rd("held_evt_c7", ID_EVT, 8'h0F);

    // 2: short glitch never reaches the debounced level
    BUTTONS = 4'h0;
    ticks(10);
    wr(ID_CLR, 8'hFF);
    expect_rd("clr_all", ID_EVT, 8'h00);
    BUTTONS = 4'h1;
    ticks(3);
    BUTTONS = 4'h0;
    ticks(8);
    expect_rd("glitch_btn", ID_BTN, 8'h00);
    expect_rd("glitch_evt", ID_EVT, 8'h00);

    // 3: masked press, latency to EVT and INTR, then clear
    wr(ID_MASK, 8'h04);
    expect_rd("mask_wr", ID_MASK, 8'h04);
    BUTTONS = 4'h4;
    ticks(6);
    expect_rd("press_evt_c6", ID_EVT, 8'h00);
    tick();
    expect_rd("press_evt_c7", ID_EVT, 8'h04);
    check("press_intr_c7", 8'(INTR), 8'h00);
    tick();
    check("press_intr_c8", 8'(INTR), 8'h01);
    wr(ID_CLR, 8'h04);
    expect_rd("press_clr_evt", ID_EVT, 8'h00);
    check("press_clr_intr_hold", 8'(INTR), 8'h01);
    tick();
    check("press_clr_intr_drop", 8'(INTR), 8'h00);

    // 4: masking controls INTR independent of pending flags
    wr(ID_MASK, 8'h00);
    BUTTONS = 4'h7;
    ticks(10);
    expect_rd("mask_evt3", ID_EVT, 8'h03);
    check("mask0_intr", 8'(INTR), 8'h00);
    wr(ID_MASK, 8'h02);
    check("mask2_intr_c1", 8'(INTR), 8'h00);
    tick();
    check("mask2_intr_c2", 8'(INTR), 8'h01);
    wr(ID_CLR, 8'h01);
    tick();
    check("clr1_intr", 8'(INTR), 8'h01);
    wr(ID_CLR, 8'h02);
    tick();
    check("clr2_intr", 8'(INTR), 8'h00);

    // 5: rise on bit1 coinciding with a clear of bit1
    BUTTONS = 4'h5;
    ticks(10);
    BUTTONS = 4'h7;
    ticks(6);
    wr(ID_CLR, 8'h02);
    expect_rd("collide_evt", ID_EVT, 8'h02);

    // 6: decode of switches, unmapped IDs and read-only IDs
    SWITCHES = 8'hA5;
    ticks(2);
    expect_rd("sw_a5", ID_SW, 8'hA5);
    expect_rd("id40", 8'h40, 8'h00);
    rd(ID_EVT, v);
    wr(ID_EVT, 8'hFF);
    expect_rd("wr_evt_ignored", ID_EVT, v);
    wr(ID_SW, 8'hFF);
    wr(ID_BTN, 8'hFF);
    expect_rd("wr_ro_mask", ID_MASK, 8'h02);

    // Random traffic against the model, with occasional mid-run resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        RESET_N = 1'b0;
        #1;
        model_reset();
        check("rnd_rst_intr", 8'(INTR), 8'h00);
        ticks(2);
        RESET_N = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) SWITCHES = 8'($urandom);
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 5) == 0) BUTTONS[b] = ~BUTTONS[b];
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       PORT_ID = ID_MASK;
          1, 2:    PORT_ID = ID_CLR;
          3:       PORT_ID = ID_EVT;
          4:       PORT_ID = ID_SW;
          default: PORT_ID = 8'($urandom);
        endcase
        OUT_PORT = 8'($urandom);
        IO_STRB  = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
